// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles the signals between the decode/execute datapath and the hazard
// controller.
//
// The datapath side uses the master modport: it drives the stage register
// addresses, write enables, result source, branch/jump and MDU signals, and
// receives the hazard outputs.
//
// The hazard controller uses the slave modport: it samples those inputs and
// drives the forward selects, stalls, flushes, mc_go, mc_timeout and state_o.
//
// MDU handshake:
//   - mc_go is a single-cycle start pulse. The MDU latches its operands on it.
//   - mc_done is a single-cycle result-valid pulse. The controller honours it
//     only while it is waiting in MC_BUSY; any other mc_done is dropped.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] rs1_D;
   logic [REG_AW-1:0] rs2_D;
   logic [REG_AW-1:0] rs1_E;
   logic [REG_AW-1:0] rs2_E;
   logic [REG_AW-1:0] rd_E;
   logic [REG_AW-1:0] rd_M;
   logic [REG_AW-1:0] rd_W;
   logic              write_enable_RF_M;
   logic              write_enable_RF_W;
   logic [1:0]        write_back_E;
   logic              pc_src_E;
   logic              mc_start_E;
   logic              mc_done;

   logic [1:0]        forwardAE;
   logic [1:0]        forwardBE;
   logic              stallF;
   logic              stallD;
   logic              stallE;
   logic              flushD;
   logic              flushE;
   logic              flushM;
   logic              mc_go;
   logic              mc_timeout;
   logic [1:0]        state_o;

   modport master (
      output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      output write_enable_RF_M, write_enable_RF_W, write_back_E,
      output pc_src_E, mc_start_E, mc_done,
      input  forwardAE, forwardBE, stallF, stallD, stallE,
      input  flushD, flushE, flushM, mc_go, mc_timeout, state_o
   );

   modport slave (
      input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      input  write_enable_RF_M, write_enable_RF_W, write_back_E,
      input  pc_src_E, mc_start_E, mc_done,
      output forwardAE, forwardBE, stallF, stallD, stallE,
      output flushD, flushE, flushM, mc_go, mc_timeout, state_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for a 5-stage RISC-V pipeline. It handles:
//   - E-stage operand forwarding. M has priority over W, and x0 is never
//     forwarded.
//   - Load-use stalls lasting LOAD_LAT cycles.
//   - Flushes on taken branches and jumps.
//   - An optional freeze around a multi-cycle execute unit (MDU), with a
//     timeout.
//
// Macro HAZARD_MC_EN:
//   - Defined: the MDU path is built (MC_BUSY, busy counter, mc_go and the
//     sticky mc_timeout flag).
//   - Undefined: mc_start_E and mc_done are ignored, and stallE, flushM,
//     mc_go and mc_timeout stay 0.
//
// Parameters:
//   REG_AW     - register address width. Must match the interface instance.
//   LOAD_LAT   - stall cycles per load-use hazard (1..4).
//   MC_TIMEOUT - maximum MC_BUSY cycles before abort. 0 disables the timeout.
//
// Ports:
//   clk   - rising-edge clock.
//   reset - asynchronous, active-high reset.
//   bus   - hazard_ctrl_if.slave: stage addresses and controls in, forward
//           selects, stalls, flushes, MDU controls and state_o out.
//           state_o encoding: 00 RUN, 01 LOAD_STALL, 10 MC_BUSY.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int LOAD_LAT   = 1,
   parameter int MC_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MC_BUSY    = 2'b10
   } state_t;

   // Wide enough to hold MC_TIMEOUT-1.
   localparam int BW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

   state_t     state;
   logic [2:0] load_cnt;
   logic       load_use;
   logic       mc_req;
   logic       mc_release;

   // M wins over W because it holds the younger result.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rd_m,
      input logic              we_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              we_w
   );
      fwd_sel = 2'b00;
      if (rs != '0) begin
         if (we_m && (rd_m == rs)) begin
            fwd_sel = 2'b10;
         end else if (we_w && (rd_w == rs)) begin
            fwd_sel = 2'b01;
         end
      end
   endfunction

   always_comb begin
      load_use = (bus.write_back_E == 2'b01) && (bus.rd_E != '0) &&
                 ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));
   end

`ifdef HAZARD_MC_EN
   logic [BW-1:0] busy_cnt;
   logic          timeout_q;
   logic          timeout_hit;

   always_comb begin
      mc_req      = bus.mc_start_E;
      timeout_hit = (MC_TIMEOUT != 0) && (busy_cnt == BW'(MC_TIMEOUT - 1));
      // The freeze is released in the cycle that ends it, whether by
      // mc_done or by timeout.
      mc_release  = bus.mc_done || timeout_hit;
   end
`else
   logic unused_mc;

   always_comb begin
      mc_req     = 1'b0;
      mc_release = 1'b0;
      unused_mc  = bus.mc_start_E ^ bus.mc_done;
   end
`endif

   // Outputs are decoded from the current state and the live inputs. This
   // gives zero-latency response in RUN. Reset forces them quiet immediately.
   always_comb begin
      bus.forwardAE = 2'b00;
      bus.forwardBE = 2'b00;
      bus.stallF    = 1'b0;
      bus.stallD    = 1'b0;
      bus.stallE    = 1'b0;
      bus.flushD    = 1'b0;
      bus.flushE    = 1'b0;
      bus.flushM    = 1'b0;
      bus.mc_go     = 1'b0;
      bus.state_o   = state;
`ifdef HAZARD_MC_EN
      bus.mc_timeout = timeout_q;
`else
      bus.mc_timeout = 1'b0;
`endif
      if (!reset) begin
         bus.forwardAE = fwd_sel(bus.rs1_E, bus.rd_M, bus.write_enable_RF_M,
                                 bus.rd_W, bus.write_enable_RF_W);
         bus.forwardBE = fwd_sel(bus.rs2_E, bus.rd_M, bus.write_enable_RF_M,
                                 bus.rd_W, bus.write_enable_RF_W);
         case (state)
            RUN: begin
               if (load_use) begin
                  bus.stallF = 1'b1;
                  bus.stallD = 1'b1;
                  bus.flushE = 1'b1;
               end
               if (bus.pc_src_E) begin
                  bus.flushD = 1'b1;
                  bus.flushE = 1'b1;
               end
               if (mc_req) begin
                  bus.mc_go  = 1'b1;
                  bus.stallF = 1'b1;
                  bus.stallD = 1'b1;
                  bus.stallE = 1'b1;
                  bus.flushM = 1'b1;
               end
            end
            LOAD_STALL: begin
               bus.stallF = 1'b1;
               bus.stallD = 1'b1;
               bus.flushE = 1'b1;
            end
            MC_BUSY: begin
               if (!mc_release) begin
                  bus.stallF = 1'b1;
                  bus.stallD = 1'b1;
                  bus.stallE = 1'b1;
                  bus.flushM = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         load_cnt <= 3'd0;
`ifdef HAZARD_MC_EN
         busy_cnt  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state)
            RUN: begin
               if (load_use) begin
                  // The RUN cycle is the first stall cycle. LOAD_STALL
                  // covers the remaining LOAD_LAT-1 cycles.
                  if (LOAD_LAT > 1) begin
                     load_cnt <= 3'(LOAD_LAT - 1);
                     state    <= LOAD_STALL;
                  end
               end else if (mc_req) begin
`ifdef HAZARD_MC_EN
                  busy_cnt <= '0;
`endif
                  state <= MC_BUSY;
               end
            end
            LOAD_STALL: begin
               load_cnt <= load_cnt - 3'd1;
               if (load_cnt == 3'd1) begin
                  state <= RUN;
               end
            end
            MC_BUSY: begin
`ifdef HAZARD_MC_EN
               if (bus.mc_done) begin
                  state <= RUN;
               end else if (timeout_hit) begin
                  timeout_q <= 1'b1;
                  state     <= RUN;
               end else begin
                  busy_cnt <= busy_cnt + BW'(1);
               end
`else
               state <= RUN;
`endif
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule
